// File: rtl/bus_master_arb_port.sv
// Master-side arbitration port: waits for a free slave, requests the bus,
// owns it on grant, and handles split/resume and grant-wait timeout.
module bus_master_arb_port #(
  parameter int MASTER_ID     = 0,
  parameter int GRANT_TIMEOUT = 16,
  parameter int CNT_W         = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       M_START,
  input  logic [1:0] M_SLAVE_SEL,
  output logic       M_GRANTED,
  output logic       M_DONE,
  output logic       M_TIMEOUT,
  output logic       M_BADSEL,
  output logic       M_SPLIT_WAIT,
  output logic       B_REQ,
  input  logic [1:0] B_GRANT,
  output logic       B_UTIL,
  input  logic [2:0] B_SBSY,
  input  logic       B_SPLIT,
  input  logic       B_SPL_RESUME,
  input  logic       B_DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SLV,
    S_REQ,
    S_OWN,
    S_SPLIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             done_d, tout_d, bad_d;
  logic             req_q, util_q, gnt_q, spw_q;
  logic             done_q, tout_q, bad_q;
  logic             my_grant;

  // Only this master's grant bit matters; the other is deliberately ignored.
  logic unused_grant;
  assign unused_grant = B_GRANT[1 - MASTER_ID];
  assign my_grant     = B_GRANT[MASTER_ID];

  // Next-state, counter and one-shot pulse decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    bad_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (M_START) begin
          if (M_SLAVE_SEL == 2'd3) begin
            bad_d = 1'b1;
          end else begin
            sel_d   = M_SLAVE_SEL;
            state_d = S_WAIT_SLV;
          end
        end
      end
      S_WAIT_SLV: begin
        if (!B_SBSY[sel_q]) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        // Grant beats a coincident timeout.
        if (my_grant) begin
          state_d = S_OWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OWN: begin
        // Done takes priority over split; grant loss is ignored here.
        if (B_DONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (B_SPLIT) begin
          state_d = S_SPLIT;
        end
      end
      S_SPLIT: begin
        if (B_SPL_RESUME) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, latched select and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      req_q   <= 1'b0;
      util_q  <= 1'b0;
      gnt_q   <= 1'b0;
      spw_q   <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      req_q   <= (state_d == S_REQ) || (state_d == S_OWN);
      util_q  <= (state_d == S_OWN);
      gnt_q   <= (state_d == S_OWN);
      spw_q   <= (state_d == S_SPLIT);
      done_q  <= done_d;
      tout_q  <= tout_d;
      bad_q   <= bad_d;
    end
  end

  assign B_REQ        = req_q;
  assign B_UTIL       = util_q;
  assign M_GRANTED    = gnt_q;
  assign M_SPLIT_WAIT = spw_q;
  assign M_DONE       = done_q;
  assign M_TIMEOUT    = tout_q;
  assign M_BADSEL     = bad_q;

endmodule

// File: tb/tb_bus_master_arb_port.sv
// Directed scoreboard bench for bus_master_arb_port.
// Two instances: MASTER_ID=0 and MASTER_ID=1, both with GRANT_TIMEOUT=4.
module tb_bus_master_arb_port;

  // Output vector: {GRANTED, DONE, TIMEOUT, BADSEL, SPLIT_WAIT, REQ, UTIL}
  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] RQ = 7'b0000010;
  localparam logic [6:0] OW = 7'b1000011;
  localparam logic [6:0] DP = 7'b0100000;
  localparam logic [6:0] TP = 7'b0010000;
  localparam logic [6:0] BP = 7'b0001000;
  localparam logic [6:0] SW = 7'b0000100;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [1:0] grant = 2'd0;
  logic [2:0] sbsy = 3'd0;
  logic       split = 1'b0;
  logic       resume = 1'b0;
  logic       bdone = 1'b0;

  logic g0, d0, t0, b0, w0, r0, u0;
  logic g1, d1, t1, b1, w1, r1, u1;

  logic [6:0] q0[$];
  logic [6:0] q1[$];
  int checks = 0;
  int errors = 0;
  int stepn  = 0;

  always #5 CLK = ~CLK;

  bus_master_arb_port #(
    .MASTER_ID(0), .GRANT_TIMEOUT(4), .CNT_W(5)
  ) dut0 (
    .CLK(CLK), .RST(RST),
    .M_START(start0), .M_SLAVE_SEL(sel),
    .M_GRANTED(g0), .M_DONE(d0), .M_TIMEOUT(t0),
    .M_BADSEL(b0), .M_SPLIT_WAIT(w0),
    .B_REQ(r0), .B_GRANT(grant), .B_UTIL(u0),
    .B_SBSY(sbsy), .B_SPLIT(split),
    .B_SPL_RESUME(resume), .B_DONE(bdone)
  );

  bus_master_arb_port #(
    .MASTER_ID(1), .GRANT_TIMEOUT(4), .CNT_W(5)
  ) dut1 (
    .CLK(CLK), .RST(RST),
    .M_START(start1), .M_SLAVE_SEL(sel),
    .M_GRANTED(g1), .M_DONE(d1), .M_TIMEOUT(t1),
    .M_BADSEL(b1), .M_SPLIT_WAIT(w1),
    .B_REQ(r1), .B_GRANT(grant), .B_UTIL(u1),
    .B_SBSY(sbsy), .B_SPLIT(split),
    .B_SPL_RESUME(resume), .B_DONE(bdone)
  );

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(
    input logic       s0,
    input logic       s1,
    input logic [1:0] sl,
    input logic [1:0] g,
    input logic [2:0] sb,
    input logic       sp,
    input logic       rs,
    input logic       dn,
    input logic [6:0] e0,
    input logic [6:0] e1
  );
    @(negedge CLK);
    start0 = s0;
    start1 = s1;
    sel    = sl;
    grant  = g;
    sbsy   = sb;
    split  = sp;
    resume = rs;
    bdone  = dn;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // Monitor: compare DUT outputs against queued expectations each cycle.
  initial begin
    logic [6:0] e0, e1, a0, a1;
    forever begin
      @(negedge CLK);
      #1;
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        a0 = {g0, d0, t0, b0, w0, r0, u0};
        a1 = {g1, d1, t1, b1, w1, r1, u1};
        checks++;
        if (a0 !== e0) begin
          errors++;
          $display("FAIL dut0 step %0d: got %b want %b",
                   stepn, a0, e0);
        end
        checks++;
        if (a1 !== e1) begin
          errors++;
          $display("FAIL dut1 step %0d: got %b want %b",
                   stepn, a1, e1);
        end
        stepn++;
      end
    end
  end

  initial begin
    // Reset state
    #1 RST = 1'b1;
    step(0,0,0,0,0,0,0,0, Z, Z);
    step(0,0,0,0,0,0,0,0, Z, Z);
    RST = 1'b0;
    step(0,0,0,0,0,0,0,0, Z, Z);

    // Basic: REQ at +2, UTIL one cycle after grant, DONE pulse
    step(1,0,1,0,0,0,0,0, Z,  Z);
    step(0,0,1,0,0,0,0,0, Z,  Z);
    step(0,0,0,0,0,0,0,0, RQ, Z);
    step(0,0,0,1,0,0,0,0, RQ, Z);
    step(0,0,0,0,0,0,0,0, OW, Z);
    step(1,0,3,2,0,0,0,0, OW, Z);
    step(0,0,0,0,0,0,0,0, OW, Z);
    step(0,0,0,0,0,0,0,0, OW, Z);
    step(0,0,0,0,0,0,0,1, OW, Z);
    step(0,0,0,0,0,0,0,0, DP, Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);

    // Slave busy; select is not re-sampled while waiting
    step(1,0,2,0,3'b100,0,0,0, Z, Z);
    repeat (5) step(0,0,0,0,3'b100,0,0,0, Z, Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);
    step(0,0,0,1,0,0,0,0, RQ, Z);
    step(0,0,0,0,0,0,0,1, OW, Z);
    step(0,0,0,0,0,0,0,0, DP, Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);

    // Timeout: REQ for 4 cycles, other grant bit ignored
    step(1,0,0,0,0,0,0,0, Z,  Z);
    step(0,0,0,2,0,0,0,0, Z,  Z);
    step(0,0,0,2,0,0,0,0, RQ, Z);
    step(0,0,0,2,0,0,0,0, RQ, Z);
    step(0,0,0,2,0,0,0,0, RQ, Z);
    step(0,0,0,2,0,0,0,0, RQ, Z);
    // Restart on the timeout-pulse cycle; grant on 4th REQ cycle wins
    step(1,0,0,0,0,0,0,0, TP, Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);
    step(0,0,0,0,0,0,0,0, RQ, Z);
    step(0,0,0,0,0,0,0,0, RQ, Z);
    step(0,0,0,0,0,0,0,0, RQ, Z);
    step(0,0,0,1,0,0,0,0, RQ, Z);
    // DONE and SPLIT together: DONE wins
    step(0,0,0,0,0,1,0,1, OW, Z);
    step(0,0,0,0,0,0,0,0, DP, Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);

    // Illegal select
    step(1,0,3,0,0,0,0,0, Z,  Z);
    step(0,0,0,0,0,0,0,0, BP, Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);

    // Split, resume after 3 cycles, regrant on last allowed cycle
    step(1,0,2,0,0,0,0,0, Z,  Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);
    step(0,0,0,1,0,0,0,0, RQ, Z);
    step(0,0,0,1,0,1,0,0, OW, Z);
    step(0,0,0,0,3'b100,0,0,0, SW, Z);
    step(0,0,0,0,3'b100,1,0,0, SW, Z);
    step(0,0,0,0,3'b100,0,1,0, SW, Z);
    step(0,0,0,0,0,0,0,0, RQ, Z);
    step(0,0,0,0,0,0,0,0, RQ, Z);
    step(0,0,0,0,0,0,0,0, RQ, Z);
    step(0,0,0,1,0,0,0,0, RQ, Z);
    step(0,0,0,0,0,0,0,1, OW, Z);
    step(0,0,0,0,0,0,0,0, DP, Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);

    // MASTER_ID=1: bit 0 grants never own, times out
    step(0,1,0,0,0,0,0,0, Z, Z);
    step(0,0,0,1,0,0,0,0, Z, Z);
    step(0,0,0,1,0,0,0,0, Z, RQ);
    step(0,0,0,1,0,0,0,0, Z, RQ);
    step(0,0,0,1,0,0,0,0, Z, RQ);
    step(0,0,0,1,0,0,0,0, Z, RQ);
    step(0,0,0,0,0,0,0,0, Z, TP);
    step(0,0,0,0,0,0,0,0, Z, Z);
    // MASTER_ID=1: bit 1 grant owns
    step(0,1,1,0,0,0,0,0, Z, Z);
    step(0,0,0,0,0,0,0,0, Z, Z);
    step(0,0,0,2,0,0,0,0, Z, RQ);
    step(0,0,0,0,0,0,0,1, Z, OW);
    step(0,0,0,0,0,0,0,0, Z, DP);
    step(0,0,0,0,0,0,0,0, Z, Z);

    // Reset mid-OWN, asserted between edges
    step(1,0,1,0,0,0,0,0, Z,  Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);
    step(0,0,0,1,0,0,0,0, RQ, Z);
    step(0,0,0,0,0,0,0,0, OW, Z);
    @(posedge CLK);
    #2 RST = 1'b1;
    step(0,0,0,0,0,0,0,0, Z, Z);
    RST = 1'b0;
    step(0,0,0,0,0,0,0,0, Z,  Z);
    step(1,0,1,0,0,0,0,0, Z,  Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);
    step(0,0,0,1,0,0,0,0, RQ, Z);
    step(0,0,0,0,0,0,0,1, OW, Z);
    step(0,0,0,0,0,0,0,0, DP, Z);
    step(0,0,0,0,0,0,0,0, Z,  Z);

    repeat (3) @(negedge CLK);
    #2;
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_arb_port.md
Name: bus_master_arb_port

Overview:
- Master-side counterpart of the bus arbiter: one instance sits in each bus master and runs that master's half of the arbitration handshake.
- Waits for the target slave to be free, then drives this master's request bit.
- Takes ownership on grant, signals bus utilisation, and releases on transfer done.
- Handles split (release bus, wait for resume, re-arbitrate) and a grant-wait timeout; exposes a simple start/done interface to the master core.

Parameters:
- MASTER_ID, 0, index of this master's bit in B_GRANT (0 or 1).
- GRANT_TIMEOUT, 16, cycles in REQ without grant before abort (>=1).
- CNT_W, 5, width of timeout counter (must hold GRANT_TIMEOUT).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- M_START  in  1  core request for a transaction; sampled only in IDLE.
- M_SLAVE_SEL  in  2  target slave index 0..2; latched with M_START; 3 is illegal.
- M_GRANTED  out  1  core may drive address/data (high in OWN only).
- M_DONE  out  1  one-cycle pulse: transaction completed.
- M_TIMEOUT  out  1  one-cycle pulse: grant not received in time.
- M_BADSEL  out  1  one-cycle pulse: M_START with M_SLAVE_SEL=3 rejected.
- M_SPLIT_WAIT  out  1  high while parked in SPLIT.
- B_REQ  out  1  this master's request bit to arbiter.
- B_GRANT  in  2  arbiter grant vector; only bit MASTER_ID is used.
- B_UTIL  out  1  bus-in-use indication to arbiter.
- B_SBSY  in  3  per-slave busy flags.
- B_SPLIT  in  1  slave split indication.
- B_SPL_RESUME  in  1  split resume indication.
- B_DONE  in  1  transfer complete from slave side.

Behaviour:
- All outputs are registered and driven from state and counter.
- Reset: async on RST high. State=IDLE; all outputs 0; timeout counter 0; latched select 0. Reset mid-transaction drops B_REQ/B_UTIL immediately (async) and emits no pulse.
- Per-state outputs:
  - IDLE: all outputs 0. M_START=1 with select 0..2 -> latch select, go WAIT_SLV. M_START=1 with select 3 -> M_BADSEL=1 next cycle, stay IDLE.
  - WAIT_SLV: B_REQ=0. If B_SBSY[sel]=0 -> REQ; else remain (no timeout here).
  - REQ: B_REQ=1; counter increments each cycle.
    - B_GRANT[MASTER_ID]=1 -> OWN; counter cleared.
    - Else if counter reaches GRANT_TIMEOUT-1 -> IDLE, M_TIMEOUT pulses on entry to IDLE, B_REQ drops the same edge.
    - Grant and timeout in the same cycle: grant wins.
  - OWN: B_REQ=1, B_UTIL=1, M_GRANTED=1. Priority on the same cycle: B_DONE > B_SPLIT.
    - B_DONE=1 -> IDLE; B_REQ/B_UTIL/M_GRANTED drop the next cycle and M_DONE pulses that same cycle.
    - Else B_SPLIT=1 -> SPLIT.
    - Loss of grant while in OWN is ignored; B_UTIL holds until done or split.
  - SPLIT: B_REQ=0, B_UTIL=0, M_SPLIT_WAIT=1. B_SPL_RESUME=1 -> REQ with counter cleared; no slave-busy recheck. B_SPLIT is ignored here.
- Latency:
  - M_START to B_REQ: 2 cycles when the slave is free (IDLE->WAIT_SLV->REQ).
  - Grant sampled to B_UTIL: 1 cycle.
- Pulses are exactly 1 cycle wide.
- After any return to IDLE, the block accepts a new M_START on the following cycle.
- M_START outside IDLE is ignored. M_SLAVE_SEL is not re-sampled after the latch.
- The grant bit for 1-MASTER_ID is never consulted.

Test Plan:
- Basic: MASTER_ID=0, B_SBSY=000, M_START with sel=1 at cycle 0 -> B_REQ=1 at cycle 2. B_GRANT=01 at cycle 3 -> B_UTIL=M_GRANTED=1 from cycle 4. B_DONE at cycle 8 -> cycle 9: B_REQ=B_UTIL=0, M_DONE=1 for one cycle.
- Slave busy: sel=2, B_SBSY=100 held 5 cycles, then 000 -> B_REQ stays 0 while busy and rises 1 cycle after busy clears; no M_TIMEOUT.
- Timeout: GRANT_TIMEOUT=4, grant never given -> B_REQ high exactly 4 cycles, then M_TIMEOUT=1 for one cycle, state IDLE. Second run: grant arrives on the 4th REQ cycle -> OWN, no timeout.
- Split: in OWN, B_SPLIT=1 -> next cycle B_UTIL=B_REQ=0, M_SPLIT_WAIT=1. B_SPL_RESUME after 3 cycles -> B_REQ=1 again. Re-grant then B_DONE -> M_DONE pulse once.
- Simultaneous and illegal: B_DONE and B_SPLIT together in OWN -> IDLE with M_DONE, no split. M_START with sel=3 -> M_BADSEL pulse, B_REQ stays 0. MASTER_ID=1 with B_GRANT=01 -> no ownership.
- Reset mid-OWN: RST asserted between clock edges -> B_REQ/B_UTIL/M_GRANTED go 0 asynchronously. After release, M_START restarts normally with no stray pulses.
